// File: rtl/interrupt_controller_pkg.sv
// Shared types for the interrupt controller: source count, register spaces,
// and nibble-group helpers for the 4-bit register port.
package interrupt_controller_pkg;

  localparam int unsigned NUM_IRQ_SOURCES = 15;
  localparam int unsigned NIB_W           = 4;

  typedef enum logic [1:0] {
    IRQ_SPACE_FACTOR = 2'b00,
    IRQ_SPACE_MASK   = 2'b01,
    IRQ_SPACE_EDGE   = 2'b10,
    IRQ_SPACE_NONE   = 2'b11
  } irq_space;

  // Group g covers sources 4g..4g+3; source 15 does not exist and reads 0.
  function automatic logic [NIB_W-1:0] nib_get(input logic [NUM_IRQ_SOURCES-1:0] v,
                                               input logic [1:0] g);
    logic [NIB_W-1:0] r;
    logic [3:0]       idx;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      idx = {g, 2'(i)};
      if (idx < 4'(NUM_IRQ_SOURCES)) r[i] = v[idx];
    end
    return r;
  endfunction

  function automatic logic [NUM_IRQ_SOURCES-1:0] nib_set(input logic [NUM_IRQ_SOURCES-1:0] v,
                                                         input logic [1:0] g,
                                                         input logic [NIB_W-1:0] d);
    logic [NUM_IRQ_SOURCES-1:0] r;
    logic [3:0]                 idx;
    r = v;
    for (int i = 0; i < 4; i++) begin
      idx = {g, 2'(i)};
      if (idx < 4'(NUM_IRQ_SOURCES)) r[idx] = d[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_source.sv
// One interrupt source: previous-sample flop, polarity-selected edge
// detection and a sticky factor flag where a new event beats a clear.
module irq_source (
  input  logic clk,
  input  logic reset_n,
  input  logic src,
  input  logic edge_sel,
  input  logic clr,
  output logic factor
);

  logic src_prev;
  logic evt_c;

  assign evt_c = edge_sel ? (src_prev & ~src) : (~src_prev & src);

  // Reset still tracks the input so a level high at release is not an event.
  always_ff @(posedge clk) begin
    src_prev <= src;
    if (!reset_n) begin
      factor <= 1'b0;
    end else if (evt_c) begin
      factor <= 1'b1;
    end else if (clr) begin
      factor <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt factor/mask/edge-select registers behind a nibble register port,
// producing the registered request vector for the microcode sequencer.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = NUM_IRQ_SOURCES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_en,
  input  logic [NUM_SOURCES-1:0] src_in,
  input  logic [3:0]             bus_addr,
  input  logic                   bus_re,
  input  logic                   bus_we,
  input  logic [NIB_W-1:0]       bus_wdata,
  output logic [NIB_W-1:0]       bus_rdata,
  output logic [NUM_SOURCES-1:0] interrupt_req,
  output logic                   irq_any
);

  irq_space               space_c;
  logic [1:0]             group_c;
  logic                   rd_c;
  logic                   wr_c;
  logic [NUM_SOURCES-1:0] factor;
  logic [NUM_SOURCES-1:0] mask;
  logic [NUM_SOURCES-1:0] edge_sel;
  logic [NUM_SOURCES-1:0] clr_c;
  logic [NUM_SOURCES-1:0] req_c;
  logic [NIB_W-1:0]       rdata_c;

  assign space_c = irq_space'(bus_addr[3:2]);
  assign group_c = bus_addr[1:0];
  // A simultaneous write wins; the read is dropped entirely.
  assign wr_c    = clk_en & bus_we;
  assign rd_c    = clk_en & bus_re & ~bus_we;
  assign req_c   = factor & mask;

  always_comb begin
    clr_c   = '0;
    rdata_c = '0;
    if (rd_c && (space_c == IRQ_SPACE_FACTOR)) begin
      clr_c = nib_set('0, group_c, 4'hF);
    end
    case (space_c)
      IRQ_SPACE_FACTOR: rdata_c = nib_get(factor, group_c);
      IRQ_SPACE_MASK:   rdata_c = nib_get(mask, group_c);
      IRQ_SPACE_EDGE:   rdata_c = nib_get(edge_sel, group_c);
      default:          rdata_c = '0;
    endcase
  end

  for (genvar n = 0; n < NUM_SOURCES; n++) begin : g_src
    irq_source u_src (
      .clk      (clk),
      .reset_n  (reset_n),
      .src      (src_in[n]),
      .edge_sel (edge_sel[n]),
      .clr      (clr_c[n]),
      .factor   (factor[n])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask          <= '0;
      edge_sel      <= '0;
      bus_rdata     <= '0;
      interrupt_req <= '0;
      irq_any       <= 1'b0;
    end else begin
      if (wr_c && (space_c == IRQ_SPACE_MASK)) begin
        mask <= nib_set(mask, group_c, bus_wdata);
      end
      if (wr_c && (space_c == IRQ_SPACE_EDGE)) begin
        edge_sel <= nib_set(edge_sel, group_c, bus_wdata);
      end
      if (rd_c) begin
        bus_rdata <= rdata_c;
      end
      interrupt_req <= req_c;
      irq_any       <= |req_c;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller: reset release,
// edge polarity, read-clear, read/event collision, masking and mid-run reset.
module tb_interrupt_controller;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic [14:0] src_in;
  logic [3:0]  bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [3:0]  bus_wdata;
  logic [3:0]  bus_rdata;
  logic [14:0] interrupt_req;
  logic        irq_any;

  int errors = 0;
  int checks = 0;

  interrupt_controller #(.NUM_SOURCES(15)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clk_en        (clk_en),
    .src_in        (src_in),
    .bus_addr      (bus_addr),
    .bus_re        (bus_re),
    .bus_we        (bus_we),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .interrupt_req (interrupt_req),
    .irq_any       (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [3:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr);
    bus_addr = addr;
    bus_re   = 1'b1;
    tick();
    bus_re   = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    clk_en    = 1'b1;
    src_in    = 15'h0001;
    bus_addr  = 4'h0;
    bus_re    = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = 4'h0;

    // Clean reset release with source 0 already high
    tick(); tick();
    chk("rst_req", interrupt_req, 15'h0000);
    chk("rst_any", 15'(irq_any), 15'h0000);
    chk("rst_rdata", 15'(bus_rdata), 15'h0000);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("release_req", interrupt_req, 15'h0000);
    end
    bus_read(4'b0000);
    chk("release_factor", 15'(bus_rdata), 15'h0000);
    src_in = 15'h0000;
    tick();
    bus_read(4'b1100);
    chk("space_none_rd", 15'(bus_rdata), 15'h0000);

    // Rising edge on source 5, read-clear
    bus_write(4'b0101, 4'b0010);
    src_in[5] = 1'b1;
    tick();
    chk("rise_lat1", interrupt_req, 15'h0000);
    tick();
    chk("rise_req", interrupt_req, 15'h0020);
    chk("rise_any", 15'(irq_any), 15'h0001);
    clk_en = 1'b0;
    bus_read(4'b0001);
    clk_en = 1'b1;
    chk("noen_rdata", 15'(bus_rdata), 15'h0000);
    chk("noen_req", interrupt_req, 15'h0020);
    bus_read(4'b0001);
    chk("rd1_rdata", 15'(bus_rdata), 15'h0002);
    chk("rd1_req_hold", interrupt_req, 15'h0020);
    tick();
    chk("rd1_req_drop", interrupt_req, 15'h0000);
    chk("rd1_any_drop", 15'(irq_any), 15'h0000);
    bus_read(4'b0001);
    chk("rd2_rdata", 15'(bus_rdata), 15'h0000);

    // Falling-edge select on source 14; group 3 bit 3 does not exist
    bus_write(4'b1011, 4'b0100);
    bus_write(4'b0111, 4'b1100);
    bus_read(4'b0111);
    chk("grp3_mask_rd", 15'(bus_rdata), 15'h0004);
    bus_read(4'b1011);
    chk("grp3_edge_rd", 15'(bus_rdata), 15'h0004);
    src_in[14] = 1'b1;
    tick(); tick();
    chk("fall_rise_none", interrupt_req, 15'h0000);
    src_in[14] = 1'b0;
    tick(); tick();
    chk("fall_req", interrupt_req, 15'h4000);
    bus_read(4'b0011);
    chk("fall_rdata", 15'(bus_rdata), 15'h0004);
    tick();
    chk("fall_clr", interrupt_req, 15'h0000);

    // Read coinciding with a new event on source 2
    src_in[2] = 1'b1;
    tick();
    src_in[2] = 1'b0;
    tick();
    src_in[2] = 1'b1;
    bus_read(4'b0000);
    chk("coll_rdata", 15'(bus_rdata), 15'h0004);
    bus_read(4'b0000);
    chk("coll_rdata2", 15'(bus_rdata), 15'h0004);
    bus_read(4'b0000);
    chk("coll_rdata3", 15'(bus_rdata), 15'h0000);

    // Masked event on source 0, then enabled
    src_in[0] = 1'b1;
    tick(); tick();
    chk("masked_req", interrupt_req, 15'h0000);
    bus_write(4'b0100, 4'b0001);
    chk("unmask_lat", interrupt_req, 15'h0000);
    tick();
    chk("unmask_req", interrupt_req, 15'h0001);
    chk("unmask_any", 15'(irq_any), 15'h0001);

    // Non-destructive mask read, then write+read together keeps bus_rdata
    bus_read(4'b0100);
    chk("mask_rd", 15'(bus_rdata), 15'h0001);
    bus_addr  = 4'b0101;
    bus_wdata = 4'b0010;
    bus_we    = 1'b1;
    bus_re    = 1'b1;
    tick();
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    chk("rw_hold", 15'(bus_rdata), 15'h0001);
    chk("rw_req", interrupt_req, 15'h0001);

    // Reset mid-operation
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_req", interrupt_req, 15'h0000);
    chk("mid_rst_any", 15'(irq_any), 15'h0000);
    chk("mid_rst_rdata", 15'(bus_rdata), 15'h0000);
    bus_read(4'b0100);
    chk("mid_rst_mask0", 15'(bus_rdata), 15'h0000);
    bus_read(4'b0111);
    chk("mid_rst_mask3", 15'(bus_rdata), 15'h0000);
    bus_read(4'b1011);
    chk("mid_rst_edge3", 15'(bus_rdata), 15'h0000);
    bus_write(4'b0100, 4'b0101);
    tick(); tick();
    chk("held_high_req", interrupt_req, 15'h0000);
    bus_read(4'b0000);
    chk("held_high_factor", 15'(bus_rdata), 15'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
